// File: rtl/demixer_pkg.sv
// demixer_pkg: shared types and constants for the bit-serial demixer.
//   state_t        - control FSM encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  - default operand/result width
//   cnt_width(w)   - bit-counter width for a w-bit operand
package demixer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // $clog2 of the operand width; the counter runs 0..w-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: 1-bit combinational subtractor cell computing m - r - b_in.
//   m     - minuend bit
//   r     - subtrahend bit
//   b_in  - incoming borrow
//   d     - difference bit
//   b_out - outgoing borrow
module full_subtractor (
    input  logic m,
    input  logic r,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = m ^ r ^ b_in;
    assign b_out = (~m & r) | (~m & b_in) | (r & b_in);

endmodule

// File: rtl/serial_demixer.sv
// serial_demixer: recovers diff_out = mix_in - ref_in (mod 2^WIDTH) one bit per
// clock, LSB first, through a single full_subtractor cell.
//   clock, reset_n       - rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake (in_ready registered)
//   mix_in, ref_in       - minuend / subtrahend words
//   out_valid / out_ready- result handshake
//   diff_out, borrow_out - result word and final borrow (mix_in < ref_in)
module serial_demixer
    import demixer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mix_in,
    input  logic [WIDTH-1:0] ref_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state, next_state;
    logic [WIDTH-1:0] mix_sr, ref_sr, res_sr;
    logic [WIDTH-1:0] res_next;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             d_bit, b_next;
    logic             accept;

    full_subtractor u_cell (
        .m     (mix_sr[0]),
        .r     (ref_sr[0]),
        .b_in  (borrow),
        .d     (d_bit),
        .b_out (b_next)
    );

    assign accept   = (state == IDLE) && in_valid && in_ready;
    assign res_next = {d_bit, res_sr[WIDTH-1:1]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   if (cnt == LAST_BIT) next_state = DONE;
            DONE:    if (out_valid && out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mix_sr     <= '0;
            ref_sr     <= '0;
            res_sr     <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            // Handshake flags follow the state being entered, so they are
            // registered yet line up with the FSM.
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        mix_sr <= mix_in;
                        ref_sr <= ref_in;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    mix_sr <= mix_sr >> 1;
                    ref_sr <= ref_sr >> 1;
                    res_sr <= res_next;
                    borrow <= b_next;
                    cnt    <= cnt + CNT_W'(1);
                    // Outputs update only on the edge entering DONE, using
                    // the final bit still in flight.
                    if (cnt == LAST_BIT) begin
                        diff_out   <= res_next;
                        borrow_out <= b_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
